// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller: register map,
// CTRL layout and the hex-to-segment decoder.
package seg7_pkg;

    localparam logic [1:0] OFS_DIG01 = 2'd0;
    localparam logic [1:0] OFS_DIG23 = 2'd1;
    localparam logic [1:0] OFS_CTRL  = 2'd2;
    localparam logic [1:0] OFS_RSVD  = 2'd3;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_HEX_BIT = 1;

    localparam logic [15:0] CTRL_RST_VAL = 16'h0001;

    // Segment pattern for a nibble, bits G..A, active high.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Digit-slot timer: counts cycles within a slot, steps the active digit at
// the end of each slot and flags the blanking window at the slot start.
module seg7_scan_timer #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic [1:0] idx_o,
    output logic       blank_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;

    // Next slot position; a disabled scan parks at digit 0, cycle 0.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!en_i) begin
            cnt_d = '0;
            idx_d = 2'd0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // Slot position registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o   = idx_q;
    assign blank_o = ({{(32-CNT_W){1'b0}}, cnt_q} < 32'(BLANK_CYCLES));

endmodule

// File: rtl/seg7_scan_ctrl.sv
// openMSP430 peripheral driving a four-digit common-anode seven-segment
// display: four digit registers, CTRL (EN/HEX) and a blanked digit scan.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR    = 15'h0090,
    parameter int          REFRESH_DIV  = 50000,
    parameter int          BLANK_CYCLES = 500
) (
    input  logic        mclk,
    input  logic        puc,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic [7:0]  seg_n,
    output logic [3:0]  an_n
);

    logic             sel_s, wr_s, rd_s;
    logic [1:0]       ofs_s;
    logic [3:0][7:0]  dig_q, dig_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [1:0]       idx_s;
    logic             blank_s;
    logic [7:0]       digit_s;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    assign sel_s = per_en && (per_addr[13:2] == BASE_ADDR[14:3]);
    assign ofs_s = per_addr[1:0];
    assign wr_s  = sel_s && (per_we != 2'b00);
    assign rd_s  = sel_s && (per_we == 2'b00);

    seg7_scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk_i  (mclk),
        .rst_i  (puc),
        .en_i   (ctrl_q[CTRL_EN_BIT]),
        .idx_o  (idx_s),
        .blank_o(blank_s)
    );

    // Byte-granular register writes.
    always_comb begin
        dig_d  = dig_q;
        ctrl_d = ctrl_q;
        if (wr_s) begin
            case (ofs_s)
                OFS_DIG01: begin
                    if (per_we[0]) dig_d[0] = per_din[7:0];  else dig_d[0] = dig_q[0];
                    if (per_we[1]) dig_d[1] = per_din[15:8]; else dig_d[1] = dig_q[1];
                end
                OFS_DIG23: begin
                    if (per_we[0]) dig_d[2] = per_din[7:0];  else dig_d[2] = dig_q[2];
                    if (per_we[1]) dig_d[3] = per_din[15:8]; else dig_d[3] = dig_q[3];
                end
                OFS_CTRL: begin
                    if (per_we[0]) ctrl_d = per_din[1:0]; else ctrl_d = ctrl_q;
                end
                default: begin
                    dig_d  = dig_q;
                    ctrl_d = ctrl_q;
                end
            endcase
        end else begin
            dig_d  = dig_q;
            ctrl_d = ctrl_q;
        end
    end

    // Combinational read mux; zero unless this block is read.
    always_comb begin
        per_dout = 16'h0000;
        if (rd_s) begin
            case (ofs_s)
                OFS_DIG01: per_dout = {dig_q[1], dig_q[0]};
                OFS_DIG23: per_dout = {dig_q[3], dig_q[2]};
                OFS_CTRL:  per_dout = {14'h0000, ctrl_q};
                default:   per_dout = 16'h0000;
            endcase
        end else begin
            per_dout = 16'h0000;
        end
    end

    // Display drive for the current slot, blanked when disabled or early in the slot.
    always_comb begin
        digit_s = dig_q[idx_s];
        an_d    = 4'hF;
        seg_d   = 8'hFF;
        if (!ctrl_q[CTRL_EN_BIT] || blank_s) begin
            an_d  = 4'hF;
            seg_d = 8'hFF;
        end else begin
            an_d = ~(4'b0001 << idx_s);
            if (ctrl_q[CTRL_HEX_BIT]) begin
                seg_d = ~{digit_s[7], hex7(digit_s[3:0])};
            end else begin
                seg_d = ~digit_s;
            end
        end
    end

    // Register file and output registers; reset wins over a concurrent write.
    always_ff @(posedge mclk) begin
        if (puc) begin
            dig_q  <= '0;
            ctrl_q <= CTRL_RST_VAL[1:0];
            seg_q  <= 8'hFF;
            an_q   <= 4'hF;
        end else begin
            dig_q  <= dig_d;
            ctrl_q <= ctrl_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg_n = seg_q;
    assign an_n  = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized scoreboard bench for seg7_scan_ctrl with a cycle-level
// reference model derived from elapsed scan time.
module tb_seg7_scan_ctrl;

    localparam int R = 8;
    localparam int B = 2;

    logic        mclk = 1'b0;
    logic        puc = 1'b1;
    logic [13:0] per_addr = 14'h0000;
    logic [15:0] per_din = 16'h0000;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = 2'b00;
    logic [15:0] per_dout;
    logic [7:0]  seg_n;
    logic [3:0]  an_n;

    always #5 mclk = ~mclk;

    seg7_scan_ctrl #(
        .BASE_ADDR   (15'h0090),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .mclk    (mclk),
        .puc     (puc),
        .per_addr(per_addr),
        .per_din (per_din),
        .per_en  (per_en),
        .per_we  (per_we),
        .per_dout(per_dout),
        .seg_n   (seg_n),
        .an_n    (an_n)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: register image plus cycles elapsed since the scan was (re)started.
    logic [7:0]  m_dig [4];
    logic        m_en  = 1'b1;
    logic        m_hex = 1'b0;
    int          m_t   = 0;

    logic [11:0] exp_q [$];
    logic [15:0] rd_q  [$];

    function automatic logic [15:0] model_read(input logic [13:0] a);
        int b;
        b = int'(a) * 2;
        if (b < 32'h90 || b > 32'h97) return 16'h0000;
        case ((b - 32'h90) / 2)
            0:       return {m_dig[1], m_dig[0]};
            1:       return {m_dig[3], m_dig[2]};
            2:       return {14'h0000, m_hex, m_en};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_write(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        int b;
        b = int'(a) * 2;
        if (b >= 32'h90 && b <= 32'h97) begin
            case ((b - 32'h90) / 2)
                0: begin
                    if (we[0]) m_dig[0] = d[7:0];
                    if (we[1]) m_dig[1] = d[15:8];
                end
                1: begin
                    if (we[0]) m_dig[2] = d[7:0];
                    if (we[1]) m_dig[3] = d[15:8];
                end
                2: if (we[0]) begin
                    m_en  = d[0];
                    m_hex = d[1];
                end
                default: ;
            endcase
        end
    endtask

    // Reference model: predicts the outputs each edge will register.
    initial begin : model
        int cnt, idx;
        logic [7:0] d;
        logic [3:0] an;
        logic [7:0] sg;
        forever begin
            @(posedge mclk);
            if (puc) begin
                for (int i = 0; i < 4; i++) m_dig[i] = 8'h00;
                m_en  = 1'b1;
                m_hex = 1'b0;
                m_t   = 0;
                exp_q.push_back(12'hFFF);
            end else begin
                cnt = m_t % R;
                idx = (m_t / R) % 4;
                if (!m_en || cnt < B) begin
                    an = 4'hF;
                    sg = 8'hFF;
                end else begin
                    an = 4'hF & ~(4'b0001 << idx);
                    d  = m_dig[idx];
                    sg = m_hex ? ~{d[7], hex_tab[d[3:0]]} : ~d;
                end
                exp_q.push_back({an, sg});
                m_t = m_en ? m_t + 1 : 0;
                if (per_en && per_we != 2'b00) model_write(per_addr, per_din, per_we);
            end
        end
    end

    // Monitor: compares registered outputs and bus reads away from the active edge.
    initial begin : monitor
        logic [11:0] e;
        logic [15:0] r;
        forever begin
            @(negedge mclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({an_n, seg_n} !== e) begin
                    errors++;
                    $display("FAIL scan_out @%0t: an_n=%h seg_n=%h, required an_n=%h seg_n=%h",
                             $time, an_n, seg_n, e[11:8], e[7:0]);
                end
                checks++;
                if (!(an_n == 4'hF || $countones(~an_n) == 1)) begin
                    errors++;
                    $display("FAIL anode_onehot @%0t: an_n=%h, required F or a single low bit", $time, an_n);
                end
            end
            if (per_en && per_we == 2'b00 && rd_q.size() > 0) begin
                r = rd_q.pop_front();
                checks++;
                if (per_dout !== r) begin
                    errors++;
                    $display("FAIL bus_read @%0t addr=%h: per_dout=%h, required %h",
                             $time, per_addr, per_dout, r);
                end
            end
        end
    end

    task automatic drive(input logic en, input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        @(posedge mclk);
        #1;
        per_en   = en;
        per_addr = a;
        per_din  = d;
        per_we   = we;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 14'h0000, 16'h0000, 2'b00);
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        drive(1'b1, a, d, we);
    endtask

    task automatic rd(input logic [13:0] a);
        drive(1'b1, a, 16'h0000, 2'b00);
        rd_q.push_back(model_read(a));
    endtask

    task automatic reset_with_write();
        @(posedge mclk);
        #1;
        puc = 1'b1; per_en = 1'b1; per_addr = 14'h004A; per_din = 16'h0002; per_we = 2'b01;
        @(posedge mclk);
        #1;
        puc = 1'b0; per_en = 1'b0; per_addr = 14'h0000; per_din = 16'h0000; per_we = 2'b00;
    endtask

    task automatic wait_phase(input int target, input string nm);
        for (int k = 0; k < 80; k++) begin
            if (m_en && (m_t % (4 * R)) == target) break;
            idle(1);
        end
        checks++;
        if (!(m_en && (m_t % (4 * R)) == target)) begin
            errors++;
            $display("FAIL wait_%s: scan phase %0d not reached, required %0d", nm, m_t % (4 * R), target);
        end
    endtask

    initial begin : stimulus
        logic [15:0] d;
        logic [1:0]  we;
        logic [13:0] a;
        int          r;
        repeat (2) @(posedge mclk);
        #1 puc = 1'b0;

        idle(40);
        rd(14'h0048); rd(14'h0049); rd(14'h004A);

        wr(14'h0048, 16'h1234, 2'b11);
        rd(14'h0048); rd(14'h0049);
        wr(14'h0049, 16'hAB00, 2'b10);
        rd(14'h0049);

        wr(14'h004A, 16'h0003, 2'b11);
        wr(14'h0048, 16'h0085, 2'b01);
        idle(36);
        wr(14'h004A, 16'h0001, 2'b11);
        idle(36);

        wait_phase(2 * R + 3, "slot2");
        wr(14'h004A, 16'h0000, 2'b11);
        idle(5);
        rd(14'h004A);
        wr(14'h004A, 16'h0001, 2'b01);
        idle(12);

        wait_phase(3 * R + 2, "slot3");
        reset_with_write();
        rd(14'h0048); rd(14'h0049); rd(14'h004A);
        idle(12);

        wr(14'h004B, 16'hFFFF, 2'b11);
        wr(14'h0050, 16'hFFFF, 2'b11);
        rd(14'h004B); rd(14'h0050); rd(14'h004A); rd(14'h0048);
        idle(10);

        for (int n = 0; n < 900; n++) begin
            r = $urandom_range(0, 99);
            a = 14'h0048 + 14'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? 14'h0050 : 14'h0044;
            if (r < 35) begin
                d  = 16'($urandom);
                we = 2'($urandom_range(1, 3));
                if (a == 14'h004A) d[0] = ($urandom_range(0, 9) != 0);
                wr(a, d, we);
            end else if (r < 55) begin
                rd(a);
            end else if (r < 57) begin
                reset_with_write();
            end else begin
                idle($urandom_range(1, 4));
            end
        end

        idle(3);
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL read_queue_drained: %0d reads pending, required 0", rd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
